elixirchip_es1_spu_flag_pack: RTL and testbench
===============================================

Name: elixirchip_es1_spu_flag_pack

Overview:
Serial-to-parallel flag packer. It gathers 1-bit per-cycle flag streams, such as the outputs of the SPU reduction ops (any/all), into DATA_BITS-wide words. A word is emitted when it is full or when the stream marks a last bit. It sits downstream of SPU reduction ops and feeds word-oriented stores or a host readback.

Parameters:
- LATENCY, 0: extra cke-qualified output pipeline stages after the pack register; legal range 0..3.
- DATA_BITS, 8: packed word width; legal range 1..64.
- data_t, logic [DATA_BITS-1:0]: output word type.
- FILL_BIT, 1'b0: value of unfilled bit positions in a short (s_last) word.
- DEVICE, "RTL": target device; "RTL" or "ULTRASCALE_PLUS". No functional difference.
- SIMULATION, "false": simulation-only checks enabled when "true".
- DEBUG, "false": debug attributes when "true".
- COUNT_BITS (localparam): $clog2(DATA_BITS+1).

Ports:
- reset  in  1  synchronous, active-high reset
- clk  in  1  clock
- cke  in  1  clock enable; 0 freezes all state and outputs
- s_data  in  1  input flag bit
- s_clear  in  1  discard the partial word; qualified by s_valid
- s_last  in  1  this bit closes the word early; qualified by s_valid
- s_valid  in  1  input bit valid
- m_data  out  DATA_BITS  packed word; bit k = k-th accepted flag, LSB first
- m_count  out  COUNT_BITS  number of meaningful bits in m_data, 1..DATA_BITS
- m_valid  out  1  word valid, one cke-cycle pulse per word

Behaviour:
- Accept condition: cke & s_valid & ~s_clear. All state updates require cke=1.
- Internal state:
  - cnt, 0..DATA_BITS-1: next bit position.
  - pack register, DATA_BITS wide, preset to all FILL_BIT.
- On accept:
  - pack[cnt] <= s_data.
  - If cnt==DATA_BITS-1 or s_last=1, emit the word: stage0 data = pack with bit cnt replaced by s_data; count = cnt+1; valid = 1.
  - After an emit: cnt <= 0 and pack <= all FILL_BIT.
  - Otherwise cnt <= cnt+1.
- s_clear with cke & s_valid:
  - cnt <= 0, pack <= all FILL_BIT, no word emitted.
  - The s_data and s_last of that cycle are ignored; clear takes precedence.
- cke=1 with s_valid=0: stage0 valid <= 0; cnt and pack are held.
- Output timing:
  - Stage0 is a register. With LATENCY=0, m_* reflect stage0, i.e. the word is visible in the cke-cycle after the accepting edge.
  - Each LATENCY step adds one cke-qualified register; total latency is LATENCY+1 cke-cycles.
- m_valid:
  - Asserted for exactly one cke=1 cycle per word.
  - It stays high through intervening cke=0 cycles, because outputs are frozen.
  - m_data and m_count are held when m_valid=0; their value then is don't-care but stable.
- Back-to-back: a word may be emitted every accepting cycle. The next word starts at bit 0 on the cycle after an emit.
- DATA_BITS=1: every accepted bit emits a word with m_count=1.
- Reset:
  - cnt=0, pack=all FILL_BIT, all pipeline valid=0.
  - m_data=0, m_count=0, m_valid=0.
  - A partial word in flight at reset is discarded, and any words in the pipeline are dropped.
- No backpressure: the consumer must accept every m_valid pulse.
- SIMULATION="true": assert that LATENCY is in 0..3 and DATA_BITS is in 1..64.

Test Plan:
1. DATA_BITS=8, LATENCY=0, eight back-to-back valid bits 1,0,1,0,0,1,0,1 → one m_valid pulse with m_data=8'hA5, m_count=8, on the cycle after the 8th bit.
2. Bits 1,1,0 with s_last on the 3rd → m_data=8'h03, m_count=3. The next 8 bits all 1 → m_data=8'hFF, m_count=8, i.e. cnt restarted at 0.
3. Pattern from test 1 with s_valid=0 gaps and cke=0 cycles inserted mid-word and while m_valid=1 → still 8'hA5. m_valid is high for exactly one cke=1 cycle and held across cke=0.
4. Five bits of 1, then s_clear with s_data=1, s_last=1, then eight bits of 1 → exactly one word, 8'hFF, m_count=8; no partial word emitted.
5. LATENCY=3, stimulus of test 1 → 8'hA5 appears exactly 3 cke-cycles later than with LATENCY=0. Sweep DATA_BITS 1..64 × LATENCY 0..3 with a random bit stream against a reference model.
6. Reset asserted after 4 accepted bits, then bits 0,1,0,1,1,0,1,0 → m_data=8'h5A, m_count=8. All outputs are 0 during reset.

Source files
------------

// File: rtl/elixirchip_es1_spu_flag_pack.sv
// Serial-to-parallel flag packer: gathers 1-bit flags LSB first into DATA_BITS-wide words,
// closing a word when it is full or on s_last, followed by LATENCY extra output stages.
module elixirchip_es1_spu_flag_pack #(
    parameter int    LATENCY    = 0,
    parameter int    DATA_BITS  = 8,
    parameter type   data_t     = logic [DATA_BITS-1:0],
    parameter logic  FILL_BIT   = 1'b0,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false",
    localparam int   COUNT_BITS = $clog2(DATA_BITS + 1)
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,
    input  logic                  s_data,
    input  logic                  s_clear,
    input  logic                  s_last,
    input  logic                  s_valid,
    output data_t                 m_data,
    output logic [COUNT_BITS-1:0] m_count,
    output logic                  m_valid
);

    localparam data_t                 FILL_WORD = {DATA_BITS{FILL_BIT}};
    localparam logic [COUNT_BITS-1:0] LAST_POS  = COUNT_BITS'(DATA_BITS - 1);

    logic [COUNT_BITS-1:0] cnt;
    data_t                 pack;
    data_t                 pack_next;
    logic                  accept;
    logic                  clear;
    logic                  emit;

    // Index 0 is the pack output register; higher indices are the extra latency stages.
    data_t                 st_data  [LATENCY+1];
    logic [COUNT_BITS-1:0] st_count [LATENCY+1];
    logic                  st_valid [LATENCY+1];

    assign accept = cke & s_valid & ~s_clear;
    assign clear  = cke & s_valid & s_clear;
    assign emit   = accept & (s_last | (cnt == LAST_POS));

    always_comb begin
        pack_next = pack;
        for (int k = 0; k < DATA_BITS; k++) begin
            if (cnt == COUNT_BITS'(k)) begin
                pack_next[k] = s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            pack <= FILL_WORD;
        end else if (clear || emit) begin
            cnt  <= '0;
            pack <= FILL_WORD;
        end else if (accept) begin
            cnt  <= cnt + COUNT_BITS'(1);
            pack <= pack_next;
        end
    end

    // Data and count only load alongside a valid word so they stay stable between words.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= LATENCY; i++) begin
                st_valid[i] <= 1'b0;
                st_data[i]  <= '0;
                st_count[i] <= '0;
            end
        end else if (cke) begin
            st_valid[0] <= emit;
            if (emit) begin
                st_data[0]  <= pack_next;
                st_count[0] <= cnt + COUNT_BITS'(1);
            end
            for (int i = 1; i <= LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
                if (st_valid[i-1]) begin
                    st_data[i]  <= st_data[i-1];
                    st_count[i] <= st_count[i-1];
                end
            end
        end
    end

    assign m_data  = st_data[LATENCY];
    assign m_count = st_count[LATENCY];
    assign m_valid = st_valid[LATENCY];

    if (SIMULATION == "true") begin : g_sim_check
        always_ff @(posedge clk) begin
            assert (LATENCY >= 0 && LATENCY <= 3);
            assert (DATA_BITS >= 1 && DATA_BITS <= 64);
            assert (DEVICE == "RTL" || DEVICE == "ULTRASCALE_PLUS");
            assert (DEBUG == "true" || DEBUG == "false");
        end
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_flag_pack.sv
// Bench for elixirchip_es1_spu_flag_pack: several width/latency/fill configurations share one
// stimulus stream; each has a queue-based reference model and a monitor.
module tb_elixirchip_es1_spu_flag_pack;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic cke     = 1'b1;
    logic s_data  = 1'b0;
    logic s_clear = 1'b0;
    logic s_last  = 1'b0;
    logic s_valid = 1'b0;
    logic done_chk = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    localparam int NCFG = 9;
    localparam int CFG_DB   [NCFG] = '{8, 8, 1, 1, 3, 5, 13, 64, 32};
    localparam int CFG_LAT  [NCFG] = '{0, 3, 0, 2, 1, 1, 3, 0, 2};
    localparam int CFG_FILL [NCFG] = '{0, 0, 0, 1, 0, 1, 0, 0, 1};

    typedef struct {
        logic [63:0] d;
        int          c;
        int          due;
    } exp_t;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int   DB  = CFG_DB[g];
        localparam int   LAT = CFG_LAT[g];
        localparam logic FB  = (CFG_FILL[g] != 0);
        localparam int   CB  = $clog2(DB + 1);
        localparam logic [63:0] FILLW = {64{FB}} >> (64 - DB);

        logic [DB-1:0] m_data;
        logic [CB-1:0] m_count;
        logic          m_valid;

        elixirchip_es1_spu_flag_pack #(
            .LATENCY    (LAT),
            .DATA_BITS  (DB),
            .FILL_BIT   (FB),
            .SIMULATION ("true")
        ) dut (
            .reset   (reset),
            .clk     (clk),
            .cke     (cke),
            .s_data  (s_data),
            .s_clear (s_clear),
            .s_last  (s_last),
            .s_valid (s_valid),
            .m_data  (m_data),
            .m_count (m_count),
            .m_valid (m_valid)
        );

        exp_t        q[$];
        logic [63:0] acc    = FILLW;
        int          n      = 0;
        int          cyc    = 0;
        logic [63:0] last_d = '0;
        int          last_c = 0;
        int          nwords = 0;

        // Reference model: cyc counts cke=1 edges; a word is due LAT cke-cycles after its accepting edge.
        always @(posedge clk) begin : model
            logic [63:0] a;
            int          k;
            int          c;
            a = acc;
            k = n;
            c = cyc;
            if (reset) begin
                a = FILLW;
                k = 0;
                q.delete();
            end else if (cke) begin
                c = c + 1;
                if (s_valid) begin
                    if (s_clear) begin
                        a = FILLW;
                        k = 0;
                    end else begin
                        a[k] = s_data;
                        k = k + 1;
                        if (k == DB || s_last) begin
                            q.push_back('{a, k, c + LAT});
                            a = FILLW;
                            k = 0;
                        end
                    end
                end
            end
            acc <= a;
            n   <= k;
            cyc <= c;
        end

        // A word is consumed when m_valid is high ahead of a cke=1 edge.
        always @(negedge clk) begin : monitor
            exp_t e;
            logic have;
            if (!reset && cke && m_valid) begin
                have = (q.size() > 0);
                total++;
                assert (have === 1'b1) else begin
                    bad++;
                    $error("FAIL cfg%0d_unexpected_word observed=%h expected=no word", g, m_data);
                end
                if (have) begin
                    e = q.pop_front();
                    total++;
                    assert (64'(m_data) === e.d) else begin
                        bad++;
                        $error("FAIL cfg%0d_data observed=%h expected=%h", g, m_data, e.d);
                    end
                    total++;
                    assert (int'(m_count) === e.c) else begin
                        bad++;
                        $error("FAIL cfg%0d_count observed=%0d expected=%0d", g, m_count, e.c);
                    end
                    total++;
                    assert (cyc === e.due) else begin
                        bad++;
                        $error("FAIL cfg%0d_timing observed_cycle=%0d expected_cycle=%0d", g, cyc, e.due);
                    end
                end
                last_d <= 64'(m_data);
                last_c <= int'(m_count);
                nwords <= nwords + 1;
            end
        end

        always @(posedge done_chk) begin
            total++;
            assert (q.size() === 0) else begin
                bad++;
                $error("FAIL cfg%0d_missing_words observed=%0d expected=0", g, q.size());
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic d, input logic l, input logic c, input logic k);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        s_clear = c;
        cke     = k;
        @(posedge clk);
        #1;
    endtask

    task automatic bits(input logic [63:0] pat, input int len, input logic last_on_end);
        for (int i = 0; i < len; i++) begin
            step(1'b1, pat[i], last_on_end && (i == len - 1), 1'b0, 1'b1);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        int w;

        reset = 1'b1;
        idle(3);
        chk("reset_data", 64'(g_cfg[0].m_data), 64'h0);
        chk("reset_count", 64'(g_cfg[0].m_count), 64'h0);
        chk("reset_valid", 64'(g_cfg[0].m_valid), 64'h0);
        reset = 1'b0;
        idle(2);

        // Eight back-to-back bits, LSB first.
        bits(64'hA5, 8, 1'b0);
        chk("t1_valid", 64'(g_cfg[0].m_valid), 64'h1);
        chk("t1_data", 64'(g_cfg[0].m_data), 64'hA5);
        chk("t1_count", 64'(g_cfg[0].m_count), 64'd8);
        chk("t1_lat3_not_yet", 64'(g_cfg[1].m_valid), 64'h0);
        idle(1);
        chk("t1_pulse_end", 64'(g_cfg[0].m_valid), 64'h0);
        idle(2);
        chk("t5_lat3_valid", 64'(g_cfg[1].m_valid), 64'h1);
        chk("t5_lat3_data", 64'(g_cfg[1].m_data), 64'hA5);
        idle(3);

        // Short word then a full word restarting at bit 0.
        bits(64'h3, 3, 1'b1);
        chk("t2_short_data", 64'(g_cfg[0].m_data), 64'h03);
        chk("t2_short_count", 64'(g_cfg[0].m_count), 64'd3);
        bits(64'hFF, 8, 1'b0);
        chk("t2_full_data", 64'(g_cfg[0].m_data), 64'hFF);
        chk("t2_full_count", 64'(g_cfg[0].m_count), 64'd8);
        idle(4);

        // Gaps and cke=0 cycles mid-word and while the word is valid.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_data", 64'(g_cfg[0].m_data), 64'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_held_valid", 64'(g_cfg[0].m_valid), 64'h1);
        chk("t3_held_data", 64'(g_cfg[0].m_data), 64'hA5);
        idle(1);
        chk("t3_pulse_end", 64'(g_cfg[0].m_valid), 64'h0);
        idle(4);

        // Clear discards the partial word and its own data/last.
        w = g_cfg[0].nwords;
        bits(64'h1F, 5, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t4_clear_no_word", 64'(g_cfg[0].m_valid), 64'h0);
        bits(64'hFF, 8, 1'b0);
        chk("t4_data", 64'(g_cfg[0].m_data), 64'hFF);
        chk("t4_count", 64'(g_cfg[0].m_count), 64'd8);
        idle(4);
        chk("t4_word_count", 64'(g_cfg[0].nwords - w), 64'd1);

        // Reset mid-word, then a fresh full word.
        bits(64'hD, 4, 1'b0);
        reset = 1'b1;
        idle(1);
        chk("t6_reset_data", 64'(g_cfg[0].m_data), 64'h0);
        chk("t6_reset_count", 64'(g_cfg[0].m_count), 64'h0);
        chk("t6_reset_valid", 64'(g_cfg[0].m_valid), 64'h0);
        chk("t6_reset_lat3_valid", 64'(g_cfg[1].m_valid), 64'h0);
        reset = 1'b0;
        bits(64'h5A, 8, 1'b0);
        chk("t6_data", 64'(g_cfg[0].m_data), 64'h5A);
        chk("t6_count", 64'(g_cfg[0].m_count), 64'd8);
        idle(4);

        // Random stream across all configurations.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 6) != 0);
        end
        reset = 1'b0;
        idle(8);

        done_chk = 1'b1;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
